// File: rtl/gru_seq_ctrl.sv
// gru_seq_ctrl: sequencer for one GRU layer.
// It time-shares one MAC, one scale multiplier and one activation LUT across
// the z, r and h~ gates of every neuron, then runs the final state update.
// Gate-major order (all z, then all r, then all h~) makes every r[k] exist
// before any h~ recurrent term consumes it.
// Build option: define GRU_RELU_EN to select relu (act_sel=11) instead of
// tanh (act_sel=10) for the candidate gate.
module gru_seq_ctrl #(
    parameter int FIXED      = 32,
    parameter int NB_INPUTS  = 24,
    parameter int NB_NEURONS = 24,
    parameter int ACT_LAT    = 2,
    parameter int AW         = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          hold,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] bias_addr,
    output logic [AW-1:0] in_w_addr,
    output logic [AW-1:0] rec_w_addr,
    output logic [AW-1:0] vec_idx,
    output logic [1:0]    gate,
    output logic          mac_load,
    output logic          mac_en,
    output logic          mac_src,
    output logic          mac_mul_r,
    output logic          scale_en,
    output logic          act_valid,
    output logic [1:0]    act_sel,
    output logic          gate_we,
    output logic [AW-1:0] gate_idx,
    output logic          h_we,
    output logic [AW-1:0] h_idx
);

    // FIXED is the datapath width of the surrounding layer; nothing here
    // does arithmetic on data words, so it only takes part in this check.
    if (FIXED < 1 || NB_INPUTS < 1 || NB_NEURONS < 1 || ACT_LAT < 1 || ACT_LAT > 7) begin : g_param_check
        $error("gru_seq_ctrl: parameter out of range");
    end

    typedef enum logic [3:0] {
        S_IDLE,
        S_BIAS,
        S_IN,
        S_REC,
        S_SCALE,
        S_ACT,
        S_WR,
        S_UPD,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] ONE      = AW'(1);
    localparam logic [AW-1:0] M_LAST   = AW'(NB_INPUTS - 1);
    localparam logic [AW-1:0] N_LAST   = AW'(NB_NEURONS - 1);
    localparam logic [AW-1:0] ACT_LAST = AW'(ACT_LAT - 1);
    localparam logic [AW-1:0] N_W      = AW'(NB_NEURONS);
    localparam logic [AW-1:0] STRIDE   = AW'(3 * NB_NEURONS);

`ifdef GRU_RELU_EN
    localparam logic [1:0] CAND_ACT_SEL = 2'b11;
`else
    localparam logic [1:0] CAND_ACT_SEL = 2'b10;
`endif

    state_t        state_q, state_d;
    logic [1:0]    gate_q, gate_d;
    logic [AW-1:0] j_q, j_d;
    // Shared phase counter: i in IN, k in REC, latency count in ACT.
    logic [AW-1:0] cnt_q, cnt_d;

    logic [AW-1:0] bias_addr_q, in_w_addr_q, rec_w_addr_q;
    logic [AW-1:0] vec_idx_q, gate_idx_q, h_idx_q;
    logic [AW-1:0] gate_off_d, in_row_d, rec_row_d;

    // Next-state and counter update; hold freezes everything in place.
    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        j_d     = j_q;
        cnt_d   = cnt_q;
        if (!hold) begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_BIAS;
                        gate_d  = 2'd0;
                        j_d     = '0;
                        cnt_d   = '0;
                    end
                end
                S_BIAS: begin
                    state_d = S_IN;
                    cnt_d   = '0;
                end
                S_IN: begin
                    if (cnt_q == M_LAST) begin
                        state_d = S_REC;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_REC: begin
                    if (cnt_q == N_LAST) begin
                        state_d = S_SCALE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_SCALE: begin
                    state_d = S_ACT;
                    cnt_d   = '0;
                end
                S_ACT: begin
                    if (cnt_q == ACT_LAST) begin
                        state_d = S_WR;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_WR: begin
                    if (j_q != N_LAST) begin
                        j_d     = j_q + ONE;
                        state_d = S_BIAS;
                    end else if (gate_q != 2'd2) begin
                        gate_d  = gate_q + 2'd1;
                        j_d     = '0;
                        state_d = S_BIAS;
                    end else begin
                        j_d     = '0;
                        state_d = S_UPD;
                    end
                end
                S_UPD: begin
                    if (j_q == N_LAST) begin
                        j_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        j_d = j_q + ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    gate_d  = 2'd0;
                    j_d     = '0;
                    cnt_d   = '0;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Address terms for the upcoming cycle, so the registered addresses line
    // up with the strobes decoded from the same registered state.
    always_comb begin
        gate_off_d = AW'(gate_d) * N_W;
        in_row_d   = (state_d == S_IN)  ? cnt_d * STRIDE : '0;
        rec_row_d  = (state_d == S_REC) ? cnt_d * STRIDE : '0;
    end

    // State, counters and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            gate_q       <= 2'd0;
            j_q          <= '0;
            cnt_q        <= '0;
            bias_addr_q  <= '0;
            in_w_addr_q  <= '0;
            rec_w_addr_q <= '0;
            vec_idx_q    <= '0;
            gate_idx_q   <= '0;
            h_idx_q      <= '0;
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            j_q          <= j_d;
            cnt_q        <= cnt_d;
            bias_addr_q  <= gate_off_d + j_d;
            in_w_addr_q  <= in_row_d + gate_off_d + j_d;
            rec_w_addr_q <= rec_row_d + gate_off_d + j_d;
            vec_idx_q    <= (state_d == S_IN || state_d == S_REC) ? cnt_d : '0;
            gate_idx_q   <= j_d;
            h_idx_q      <= (state_d == S_UPD) ? j_d : '0;
        end
    end

    // Moore strobes; hold masks the one-cycle strobes but never busy.
    assign busy      = (state_q != S_IDLE);
    assign done      = !hold && (state_q == S_DONE);
    assign mac_load  = !hold && (state_q == S_BIAS);
    assign mac_en    = !hold && (state_q == S_IN || state_q == S_REC);
    assign mac_src   = !hold && (state_q == S_REC);
    assign mac_mul_r = !hold && (state_q == S_REC) && (gate_q == 2'd2);
    assign scale_en  = !hold && (state_q == S_SCALE);
    assign act_valid = !hold && (state_q == S_ACT) && (cnt_q == '0);
    assign act_sel   = (state_q != S_ACT) ? 2'b00 :
                       (gate_q == 2'd2)   ? CAND_ACT_SEL : 2'b01;
    assign gate_we   = !hold && (state_q == S_WR);
    assign h_we      = !hold && (state_q == S_UPD);

    assign gate       = gate_q;
    assign bias_addr  = bias_addr_q;
    assign in_w_addr  = in_w_addr_q;
    assign rec_w_addr = rec_w_addr_q;
    assign vec_idx    = vec_idx_q;
    assign gate_idx   = gate_idx_q;
    assign h_idx      = h_idx_q;

endmodule
